// File: rtl/protocol_pkg.sv
// Shared types for the synth parameter path: the synth_t frame layout,
// receiver constants and state encoding, and the reset parameter set.
package protocol_pkg;

   localparam int NUM_WAVE_GENS = 2;

   typedef enum logic [7:0] {
      SQUARE   = 8'd0,
      SIN      = 8'd1,
      SAW      = 8'd2,
      TRIANGLE = 8'd3
   } wave_shape_e;

   typedef struct packed {
      logic [31:0] freq;
      wave_shape_e shape;
   } wave_gen_t;

   typedef struct packed {
      wave_gen_t [NUM_WAVE_GENS-1:0] wave_gens;
      logic [7:0]                    reverb;
      logic [7:0]                    pan;
      logic [31:0]                   master_volume;
   } synth_t;

   localparam int         SYNTH_W     = $bits(synth_t);
   localparam int         SYNTH_BYTES = SYNTH_W / 8;
   localparam logic [7:0] SYNTH_SOF   = 8'hA5;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_PAYLOAD,
      RX_CHECK,
      RX_COMMIT
   } synth_rx_state_e;

   // Power-up parameter set: everything silent, oscillators on a sine.
   function automatic synth_t reset_synth_t();
      synth_t s;
      s = '0;
      for (int i = 0; i < NUM_WAVE_GENS; i++) s.wave_gens[i].shape = SIN;
      return s;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte watchdog for the frame receiver; only compiled when
// SYNTH_RX_TIMEOUT_EN is defined.
`ifdef SYNTH_RX_TIMEOUT_EN
module rx_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rstn,
   input  logic run_i,
   input  logic clear_i,
   output logic expire_o
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A byte arriving on the expiry cycle wins over the timeout.
   assign expire_o = run_i && !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!run_i || clear_i || expire_o) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule
`endif

// File: rtl/synth_frame_rx.sv
// Assembles SOF + payload + XOR checksum frames from the MCU byte link and
// commits each good frame atomically to synth_out. Option: SYNTH_RX_TIMEOUT_EN.
module synth_frame_rx
   import protocol_pkg::*;
   #(parameter int unsigned TIMEOUT_CYCLES = 100000)
   (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output synth_t      synth_out,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] err_count,
   output logic        busy
);

   localparam int CNT_W = $clog2(SYNTH_BYTES);

   synth_rx_state_e    state_q, state_d;
   logic [SYNTH_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         acc_q, acc_d;
   logic [7:0]         chk_q, chk_d;
   synth_t             synth_q, synth_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [15:0]        err_cnt_q, err_cnt_d;
   logic               accept;

   assign rx_ready   = (state_q != RX_COMMIT);
   assign accept     = rx_valid && rx_ready;
   assign busy       = (state_q != RX_IDLE);
   assign synth_out  = synth_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;
   assign err_count  = err_cnt_q;

`ifdef SYNTH_RX_TIMEOUT_EN
   logic timeout_expire;

   rx_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk      (clk),
      .rstn     (rstn),
      .run_i    ((state_q == RX_PAYLOAD) || (state_q == RX_CHECK)),
      .clear_i  (accept),
      .expire_o (timeout_expire)
   );
`endif

   always_comb begin
      // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d   = state_q;
      shadow_d  = shadow_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      chk_d     = chk_q;
      synth_d   = synth_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      case (state_q)
         RX_IDLE: begin
            if (accept && (rx_data == SYNTH_SOF)) begin
               state_d = RX_PAYLOAD;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         RX_PAYLOAD: begin
            if (accept) begin
               shadow_d = {shadow_q[SYNTH_W-9:0], rx_data};
               acc_d    = acc_q ^ rx_data;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(SYNTH_BYTES - 1)) state_d = RX_CHECK;
            end
         end
         RX_CHECK: begin
            if (accept) begin
               chk_d   = rx_data;
               state_d = RX_COMMIT;
            end
         end
         RX_COMMIT: begin
            state_d = RX_IDLE;
            if (chk_q == acc_q) begin
               synth_d = synth_t'(shadow_q);
               done_d  = 1'b1;
            end else begin
               err_d     = 1'b1;
               err_cnt_d = sat_inc16(err_cnt_q);
            end
         end
         default: state_d = RX_IDLE;
      endcase

`ifdef SYNTH_RX_TIMEOUT_EN
      if (timeout_expire) begin
         state_d   = RX_IDLE;
         err_d     = 1'b1;
         err_cnt_d = sat_inc16(err_cnt_q);
      end
`endif
   end

   // NOTE: registers use <= so every one of them samples the same pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= RX_IDLE;
         shadow_q  <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         chk_q     <= '0;
         synth_q   <= reset_synth_t();
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         chk_q     <= chk_d;
         synth_q   <= synth_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_synth_frame_rx.sv
// Self-checking bench for synth_frame_rx: vector table, directed corner
// sequences and random frames against a byte-stream parser model.
module tb_synth_frame_rx;
   import protocol_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   synth_t      synth_out;
   logic        frame_done;
   logic        frame_err;
   logic [15:0] err_count;
   logic        busy;

   always #5 clk = ~clk;

   synth_frame_rx #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .synth_out  (synth_out),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_count  (err_count),
      .busy       (busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [SYNTH_W-1:0] act,
                        input logic [SYNTH_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int                 cyc = 0;
   int                 done_pulses = 0;
   int                 err_pulses = 0;
   int                 ready_low = 0;
   int                 done_cyc[$];
   logic [SYNTH_W-1:0] got_q[$];
   synth_t             prev;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rstn) begin
         prev = synth_out;
      end else begin
         if (frame_done) begin
            got_q.push_back(synth_out);
            done_cyc.push_back(cyc);
            done_pulses++;
         end else begin
            check("hold_between_commits", synth_out, prev);
         end
         if (frame_err) err_pulses++;
         if (!rx_ready) ready_low++;
         prev = synth_out;
      end
   end

   // ---------------- reference model: frame parser over accepted bytes ----------------
   bit                 m_in_frame;
   logic [7:0]         m_buf[$];
   logic [SYNTH_W-1:0] exp_q[$];
   int                 exp_err_pulses = 0;
   logic [15:0]        exp_err_cnt;
   logic [SYNTH_W-1:0] exp_synth;

   function automatic logic [SYNTH_W-1:0] power_up_value();
      synth_t r;
      r = '0;
      r.wave_gens[0].shape = SIN;
      r.wave_gens[1].shape = SIN;
      return r;
   endfunction

   function automatic void model_reset();
      m_in_frame  = 1'b0;
      m_buf.delete();
      exp_err_cnt = 16'd0;
      exp_synth   = power_up_value();
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [7:0]         x;
      logic [SYNTH_W-1:0] v;
      if (!m_in_frame) begin
         if (b == 8'hA5) begin
            m_in_frame = 1'b1;
            m_buf.delete();
         end
      end else begin
         m_buf.push_back(b);
         if (m_buf.size() == SYNTH_BYTES + 1) begin
            x = 8'h00;
            v = '0;
            for (int i = 0; i < SYNTH_BYTES; i++) begin
               x = x ^ m_buf[i];
               v = (v << 8) | SYNTH_W'(m_buf[i]);
            end
            if (x == m_buf[SYNTH_BYTES]) begin
               exp_q.push_back(v);
               exp_synth = v;
            end else begin
               exp_err_pulses++;
               if (exp_err_cnt != 16'hFFFF) exp_err_cnt++;
            end
            m_in_frame = 1'b0;
         end
      end
   endfunction

`ifdef SYNTH_RX_TIMEOUT_EN
   function automatic void model_timeout();
      m_in_frame = 1'b0;
      m_buf.delete();
      exp_err_pulses++;
      if (exp_err_cnt != 16'hFFFF) exp_err_cnt++;
   endfunction
`endif

   // ---------------- drivers (all act #1 after a rising edge) ----------------
   logic [7:0] fb[0:SYNTH_BYTES+1];

   task automatic send_byte(input logic [7:0] b);
      bit r, took;
      took = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int k = 0; k < 64 && !took; k++) begin
         r = rx_ready;
         @(posedge clk);
         #1;
         if (r) took = 1'b1;
      end
      check("handshake", SYNTH_W'(took), SYNTH_W'(1));
      if (took) model_byte(b);
   endtask

   task automatic build_frame(input logic [SYNTH_W-1:0] p, input logic [7:0] flip);
      logic [7:0] x;
      x = 8'h00;
      fb[0] = 8'hA5;
      for (int i = 0; i < SYNTH_BYTES; i++) begin
         fb[i+1] = p[SYNTH_W-1-8*i -: 8];
         x = x ^ fb[i+1];
      end
      fb[SYNTH_BYTES+1] = x ^ flip;
   endtask

   task automatic send_range(input int lo, input int hi, input int gap_max);
      int g;
      for (int i = lo; i <= hi; i++) begin
         send_byte(fb[i]);
         if (gap_max > 0 && i < hi) begin
            g = $urandom_range(gap_max, 0);
            if (g > 0) begin
               rx_valid = 1'b0;
               repeat (g) @(posedge clk);
               #1;
            end
         end
      end
   endtask

   task automatic send_frame(input logic [SYNTH_W-1:0] p, input logic [7:0] flip,
                             input int gap_max, input bit hold);
      build_frame(p, flip);
      send_range(0, SYNTH_BYTES + 1, gap_max);
      if (!hold) rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle_compare(input string tag);
      idle(4);
      check({tag, "_commit_count"}, SYNTH_W'(got_q.size()), SYNTH_W'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_commit_value"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
      check({tag, "_err_pulses"}, SYNTH_W'(err_pulses), SYNTH_W'(exp_err_pulses));
      check({tag, "_err_count"}, SYNTH_W'(err_count), SYNTH_W'(exp_err_cnt));
      check({tag, "_synth_out"}, synth_out, exp_synth);
      check({tag, "_busy"}, SYNTH_W'(busy), SYNTH_W'(0));
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic check_reset_state(input string tag);
      synth_t so;
      so = synth_out;
      check({tag, "_synth_out"}, synth_out, power_up_value());
      for (int i = 0; i < NUM_WAVE_GENS; i++)
         check({tag, "_shape_sin"}, SYNTH_W'(so.wave_gens[i].shape), SYNTH_W'(SIN));
      check({tag, "_err_count"}, SYNTH_W'(err_count), SYNTH_W'(0));
      check({tag, "_busy"}, SYNTH_W'(busy), SYNTH_W'(0));
      check({tag, "_rx_ready"}, SYNTH_W'(rx_ready), SYNTH_W'(1));
      check({tag, "_frame_done"}, SYNTH_W'(frame_done), SYNTH_W'(0));
      check({tag, "_frame_err"}, SYNTH_W'(frame_err), SYNTH_W'(0));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string              name;
      logic [SYNTH_W-1:0] payload;
      logic [7:0]         flip;
      int                 n_garbage;
      bit                 exp_done;
      bit                 exp_err;
   } vec_t;

   localparam int NVEC = 6;
   vec_t       vecs[NVEC];
   logic [7:0] garbage[3];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      synth_t             s, so;
      logic [SYNTH_W-1:0] p1, p2, pa5, before_v, p;
      int                 d0, e0, r0, c0, ng;
      logic [7:0]         gb, flip;
      bit                 hold;

      s = '0;
      s.wave_gens[0].freq = 32'h0001_0000;
      s.master_volume     = 32'h0000_8000;
      p1  = s;
      p2  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      pa5 = 128'hA512_A5A5_0034_56A5_789A_BCA5_DEF0_11A5;
      garbage[0] = 8'h00;
      garbage[1] = 8'hFF;
      garbage[2] = 8'h5A;
      vecs[0] = '{"valid_basic",   p1,              8'h00, 0, 1'b1, 1'b0};
      vecs[1] = '{"bad_chk_lsb",   p2,              8'h01, 0, 1'b0, 1'b1};
      vecs[2] = '{"garbage_sof",   pa5,             8'h00, 3, 1'b1, 1'b0};
      vecs[3] = '{"all_sof_bytes", {16{8'hA5}},     8'h00, 0, 1'b1, 1'b0};
      vecs[4] = '{"bad_chk_msb",   p2,              8'h80, 0, 1'b0, 1'b1};
      vecs[5] = '{"valid_p2",      p2,              8'h00, 1, 1'b1, 1'b0};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      check_reset_state("reset");

      // table-driven frames
      for (int i = 0; i < NVEC; i++) begin
         d0 = done_pulses;
         e0 = err_pulses;
         before_v = synth_out;
         for (int g = 0; g < vecs[i].n_garbage; g++) send_byte(garbage[g]);
         send_frame(vecs[i].payload, vecs[i].flip, 1, 1'b0);
         settle_compare(vecs[i].name);
         check({vecs[i].name, "_done"}, SYNTH_W'(done_pulses - d0), SYNTH_W'(vecs[i].exp_done));
         check({vecs[i].name, "_err"}, SYNTH_W'(err_pulses - e0), SYNTH_W'(vecs[i].exp_err));
         check({vecs[i].name, "_out"}, synth_out, vecs[i].exp_done ? vecs[i].payload : before_v);
         if (i == 0) begin
            so = synth_out;
            check("field_freq0", SYNTH_W'(so.wave_gens[0].freq), SYNTH_W'(32'h0001_0000));
            check("field_master_vol", SYNTH_W'(so.master_volume), SYNTH_W'(32'h0000_8000));
            check("field_freq1", SYNTH_W'(so.wave_gens[1].freq), SYNTH_W'(0));
            check("field_err_count0", SYNTH_W'(err_count), SYNTH_W'(0));
         end
         if (i == 1) check("bad_chk_err_count1", SYNTH_W'(err_count), SYNTH_W'(1));
      end

      // commit latency: checksum accepted at edge N, output changes at N+1
      before_v = synth_out;
      p = 128'hCAFE_0001_0203_0405_0607_0809_0A0B_0C0D;
      build_frame(p, 8'h00);
      send_range(0, SYNTH_BYTES + 1, 0);
      rx_valid = 1'b0;
      check("lat_done_n", SYNTH_W'(frame_done), SYNTH_W'(0));
      check("lat_ready_commit", SYNTH_W'(rx_ready), SYNTH_W'(0));
      check("lat_out_n", synth_out, before_v);
      @(posedge clk);
      #1;
      check("lat_done_n1", SYNTH_W'(frame_done), SYNTH_W'(1));
      check("lat_out_n1", synth_out, p);
      check("lat_ready_n1", SYNTH_W'(rx_ready), SYNTH_W'(1));
      @(posedge clk);
      #1;
      check("lat_done_pulse_width", SYNTH_W'(frame_done), SYNTH_W'(0));
      settle_compare("latency");

      // back-to-back frames with rx_valid held high
      r0 = ready_low;
      c0 = done_cyc.size();
      send_frame(128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'h00, 0, 1'b1);
      send_frame(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 8'h00, 0, 1'b0);
      settle_compare("b2b");
      check("b2b_ready_low", SYNTH_W'(ready_low - r0), SYNTH_W'(2));
      check("b2b_done_count", SYNTH_W'(done_cyc.size() - c0), SYNTH_W'(2));
      if (done_cyc.size() >= c0 + 2)
         check("b2b_done_spacing", SYNTH_W'(done_cyc[c0+1] - done_cyc[c0]),
               SYNTH_W'(SYNTH_BYTES + 3));
      check("b2b_out", synth_out, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);

      // reset in the middle of a payload
      p = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
      build_frame(p, 8'h00);
      send_range(0, 10, 0);
      do_reset();
      check_reset_state("midreset");
      send_frame(p, 8'h00, 1, 1'b0);
      settle_compare("after_reset");
      check("after_reset_out", synth_out, p);

      // stall mid-payload
      p = 128'h7777_0000_1234_5678_9ABC_DEF0_0000_0007;
      build_frame(p, 8'h00);
      send_range(0, 5, 0);
      rx_valid = 1'b0;
      e0 = err_pulses;
`ifdef SYNTH_RX_TIMEOUT_EN
      repeat (14) @(posedge clk);
      #1;
      check("to_not_early_err", SYNTH_W'(err_pulses - e0), SYNTH_W'(0));
      check("to_not_early_busy", SYNTH_W'(busy), SYNTH_W'(1));
      repeat (4) @(posedge clk);
      #1;
      model_timeout();
      check("to_err_pulse", SYNTH_W'(err_pulses - e0), SYNTH_W'(1));
      check("to_err_count", SYNTH_W'(err_count), SYNTH_W'(1));
      settle_compare("timeout");
      send_frame(p, 8'h00, 1, 1'b0);
      settle_compare("after_timeout");
`else
      repeat (40) @(posedge clk);
      #1;
      check("stall_busy", SYNTH_W'(busy), SYNTH_W'(1));
      check("stall_no_err", SYNTH_W'(err_pulses - e0), SYNTH_W'(0));
      send_range(6, SYNTH_BYTES + 1, 0);
      rx_valid = 1'b0;
      settle_compare("stall_resume");
      check("stall_err_count", SYNTH_W'(err_count), SYNTH_W'(0));
`endif
      check("stall_final_out", synth_out, p);

      // random frames, garbage, corruption and back-to-back mixes
      for (int i = 0; i < 40; i++) begin
         ng = $urandom_range(2, 0);
         for (int g = 0; g < ng; g++) begin
            gb = 8'($urandom);
            if (gb == 8'hA5) gb = 8'h3C;
            send_byte(gb);
         end
         p    = {$urandom, $urandom, $urandom, $urandom};
         flip = ($urandom_range(3, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
         hold = 1'($urandom_range(1, 0));
         send_frame(p, flip, 2, hold);
         if (i % 5 == 4) settle_compare("random");
      end
      settle_compare("random_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
